// File: rtl/jt12_wrseq.sv
// ============================================================================
// jt12_wrseq - host/PCM register-write sequencer and arbiter for the JT12 MMR.
// Optional feature macro: JT12_WRSEQ_PCM_PRIO_EN (fixed PCM priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt12_wrseq #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  host_valid,
   input  logic                  host_part,
   input  logic [7:0]            host_reg,
   input  logic [7:0]            host_data,
   output logic                  host_ready,
   input  logic                  pcm_valid,
   input  logic [7:0]            pcm_data,
   output logic                  pcm_ready,
   output logic                  mmr_write,
   output logic [1:0]            mmr_addr,
   output logic [7:0]            mmr_din,
   input  logic                  mmr_busy,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  idle
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [7:0] PCM_REG = 8'h2A;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_GAP1 = 3'd2,
      S_DATA = 3'd3,
      S_GAP2 = 3'd4,
      S_WAIT = 3'd5
   } state_t;

   state_t                state;
   logic [16:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [7:0]            pcm_slot;
   logic [8:0]            sel;
   logic                  sel_vld;
   logic                  cur_part;
   logic [7:0]            cur_reg;
   logic [7:0]            cur_data;

   logic                  push;
   logic                  host_pend;
   logic                  pcm_pend;
   logic                  grant_pcm;
   logic                  grant_host;
   logic                  grant;
   logic [16:0]           head;
   logic                  g_part;
   logic [7:0]            g_reg;
   logic [7:0]            g_data;
   logic [DEPTH_LOG2:0]   level_nxt;
   logic                  pcm_empty_nxt;
   logic                  in_idle_nxt;

   assign push      = host_valid && host_ready;
   assign host_pend = (fifo_level != '0);
   assign pcm_pend  = !pcm_ready;

`ifdef JT12_WRSEQ_PCM_PRIO_EN
   assign grant_pcm = (state == S_IDLE) && pcm_pend;
`else
   logic last_pcm;
   // On a tie the source that did not win last time gets the grant.
   assign grant_pcm = (state == S_IDLE) && pcm_pend && (!host_pend || !last_pcm);
`endif
   assign grant_host = (state == S_IDLE) && host_pend && !grant_pcm;
   assign grant      = grant_host || grant_pcm;

   assign head   = mem[rd_ptr];
   assign g_part = grant_pcm ? 1'b0     : head[16];
   assign g_reg  = grant_pcm ? PCM_REG  : head[15:8];
   assign g_data = grant_pcm ? pcm_slot : head[7:0];

   assign level_nxt     = fifo_level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(grant_host);
   assign pcm_empty_nxt = grant_pcm || (pcm_ready && !pcm_valid);
   assign in_idle_nxt   = ((state == S_IDLE) && !grant) || ((state == S_WAIT) && !mmr_busy);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {host_part, host_reg, host_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         host_ready <= 1'b1;
         pcm_ready  <= 1'b1;
         pcm_slot   <= '0;
         idle       <= 1'b1;
`ifndef JT12_WRSEQ_PCM_PRIO_EN
         last_pcm   <= 1'b1;
`endif
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (grant_host)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= level_nxt;
         host_ready <= (level_nxt != FULL_LEVEL);
         if (grant_pcm)
            pcm_ready <= 1'b1;
         else if (pcm_valid && pcm_ready) begin
            pcm_ready <= 1'b0;
            pcm_slot  <= pcm_data;
         end
         idle <= (level_nxt == '0) && pcm_empty_nxt && in_idle_nxt;
`ifndef JT12_WRSEQ_PCM_PRIO_EN
         if (grant)
            last_pcm <= grant_pcm;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         mmr_write <= 1'b0;
         mmr_addr  <= 2'b00;
         mmr_din   <= 8'h00;
         sel       <= '0;
         sel_vld   <= 1'b0;
         cur_part  <= 1'b0;
         cur_reg   <= 8'h00;
         cur_data  <= 8'h00;
      end else begin
         mmr_write <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant) begin
                  cur_part <= g_part;
                  cur_reg  <= g_reg;
                  cur_data <= g_data;
                  // Register already selected: only the data cycle is needed.
                  state    <= (sel_vld && (sel == {g_part, g_reg})) ? S_DATA : S_ADDR;
               end
            end
            S_ADDR: begin
               mmr_write <= 1'b1;
               mmr_addr  <= {cur_part, 1'b0};
               mmr_din   <= cur_reg;
               sel       <= {cur_part, cur_reg};
               sel_vld   <= 1'b1;
               state     <= S_GAP1;
            end
            S_GAP1: state <= S_DATA;
            S_DATA: begin
               mmr_write <= 1'b1;
               mmr_addr  <= {cur_part, 1'b1};
               mmr_din   <= cur_data;
               state     <= S_GAP2;
            end
            S_GAP2: state <= S_WAIT;
            S_WAIT: begin
               if (!mmr_busy)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jt12_wrseq.sv
// Scoreboard bench for jt12_wrseq: expected MMR strobes are queued at stimulus
// time and popped as the DUT issues them.
`default_nettype none

module tb_jt12_wrseq;

   localparam int DL2 = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         host_valid = 1'b0;
   logic         host_part = 1'b0;
   logic [7:0]   host_reg = 8'h00;
   logic [7:0]   host_data = 8'h00;
   logic         host_ready;
   logic         pcm_valid = 1'b0;
   logic [7:0]   pcm_data = 8'h00;
   logic         pcm_ready;
   logic         mmr_write;
   logic [1:0]   mmr_addr;
   logic [7:0]   mmr_din;
   logic         mmr_busy = 1'b0;
   logic [DL2:0] fifo_level;
   logic         idle;

   int           tests = 0;
   int           fails = 0;
   int           cyc = 0;
   logic [9:0]   exp_q[$];
   logic         prev_write = 1'b0;
   logic [8:0]   ms = '0;
   logic         msv = 1'b0;

   jt12_wrseq #(.DEPTH_LOG2(DL2)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_valid(host_valid), .host_part(host_part), .host_reg(host_reg),
      .host_data(host_data), .host_ready(host_ready),
      .pcm_valid(pcm_valid), .pcm_data(pcm_data), .pcm_ready(pcm_ready),
      .mmr_write(mmr_write), .mmr_addr(mmr_addr), .mmr_din(mmr_din),
      .mmr_busy(mmr_busy), .fifo_level(fifo_level), .idle(idle)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected strobes for one write; the selected-register model decides
   // whether an address cycle is due.
   task automatic exp_write(input logic p, input logic [7:0] r, input logic [7:0] d);
      if (!(msv && ms == {p, r}))
         exp_q.push_back({p, 1'b0, r});
      exp_q.push_back({p, 1'b1, d});
      ms  = {p, r};
      msv = 1'b1;
   endtask

   task automatic step();
      logic [9:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
         if (mmr_write) begin
            tests++;
            if (prev_write) begin
               fails++;
               $display("FAIL strobe_width: mmr_write high two cycles in a row at cycle %0d, required single-cycle", cyc);
            end
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_strobe: got addr=%0d din=%02h, required no strobe", mmr_addr, mmr_din);
            end else begin
               e = exp_q.pop_front();
               if ({mmr_addr, mmr_din} !== e) begin
                  fails++;
                  $display("FAIL strobe: got addr=%0d din=%02h, required addr=%0d din=%02h",
                           mmr_addr, mmr_din, e[9:8], e[7:0]);
               end
            end
         end
         prev_write = mmr_write;
      end else begin
         prev_write = 1'b0;
      end
   endtask

   task automatic drain(input int maxc, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || idle !== 1'b1) && n < maxc) begin
         step();
         n++;
      end
      tests++;
      if (exp_q.size() != 0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL %s_drain: %0d strobes outstanding idle=%b, required 0 outstanding idle=1",
                  name, exp_q.size(), idle);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      msv = 1'b0;
      prev_write = 1'b0;
   endtask

   task automatic host_push(input logic p, input logic [7:0] r, input logic [7:0] d);
      host_valid = 1'b1;
      host_part  = p;
      host_reg   = r;
      host_data  = d;
      step();
      host_valid = 1'b0;
   endtask

   task automatic pcm_push(input logic [7:0] d);
      pcm_valid = 1'b1;
      pcm_data  = d;
      step();
      pcm_valid = 1'b0;
   endtask

   task automatic wait_data_strobe(input string name);
      int n = 0;
      while (!(mmr_write === 1'b1 && mmr_addr[0] === 1'b1) && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (!(mmr_write === 1'b1 && mmr_addr[0] === 1'b1)) begin
         fails++;
         $display("FAIL %s_wait: no data strobe within 20 cycles, got mmr_write=%b", name, mmr_write);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({mmr_write, mmr_addr, mmr_din, host_ready, pcm_ready, fifo_level, idle} !==
          {1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 4'h0, 1'b1}) begin
         fails++;
         $display("FAIL reset_values: got wr=%b addr=%0d din=%02h hr=%b pr=%b lvl=%0d idle=%b, required 0 0 00 1 1 0 1",
                  mmr_write, mmr_addr, mmr_din, host_ready, pcm_ready, fifo_level, idle);
      end
      rst_n = 1'b1;
      step();
      step();
      tests++;
      if ({mmr_write, idle} !== 2'b01) begin
         fails++;
         $display("FAIL post_reset_quiet: got wr=%b idle=%b, required 0 1", mmr_write, idle);
      end
   endtask

   task automatic test_host_write();
      logic [3:0] pat;
      do_reset();
      exp_write(1'b0, 8'h28, 8'hF0);
      host_push(1'b0, 8'h28, 8'hF0);          // accepted at edge N
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         pat[i] = mmr_write;
      end
      tests++;
      if (pat !== 4'b1010) begin
         fails++;
         $display("FAIL host_timing: strobe pattern N+1..N+4 got %b, required 0101 (LSB first)", pat);
      end
      drain(20, "host_write");
      // Same register again: data cycle only, strobe at N+2.
      exp_write(1'b0, 8'h28, 8'h5A);
      host_push(1'b0, 8'h28, 8'h5A);
      step();
      step();
      tests++;
      if ({mmr_write, mmr_addr} !== 3'b101) begin
         fails++;
         $display("FAIL skip_timing: at N+2 got wr=%b addr=%0d, required wr=1 addr=1", mmr_write, mmr_addr);
      end
      drain(20, "skip");
   endtask

   task automatic test_pcm_pair();
      int cnt = 0;
      exp_write(1'b0, 8'h2A, 8'h80);
      pcm_push(8'h80);
      wait_data_strobe("pcm_first");
      mmr_busy = 1'b1;
      tests++;
      if (pcm_ready !== 1'b1) begin
         fails++;
         $display("FAIL pcm_ready_after_grant: got %b, required 1", pcm_ready);
      end
      exp_write(1'b0, 8'h2A, 8'h81);
      pcm_push(8'h81);
      repeat (5) begin
         step();
         if (mmr_write) cnt++;
      end
      tests++;
      if (cnt != 0) begin
         fails++;
         $display("FAIL pcm_busy_hold: got %0d strobes while busy, required 0", cnt);
      end
      mmr_busy = 1'b0;
      drain(20, "pcm_pair");
   endtask

   task automatic test_fifo_full();
      int n = 0;
      do_reset();
      exp_write(1'b0, 8'h30, 8'h01);
      host_push(1'b0, 8'h30, 8'h01);
      wait_data_strobe("fifo_prelim");
      mmr_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         host_valid = 1'b1;
         host_part  = 1'b0;
         host_reg   = 8'(8'h40 + i);
         host_data  = 8'(i);
         exp_write(1'b0, host_reg, host_data);
         step();
      end
      host_reg  = 8'h50;                       // ninth push, must be dropped
      host_data = 8'hEE;
      step();
      host_valid = 1'b0;
      tests++;
      if ({fifo_level, host_ready} !== {4'd8, 1'b0}) begin
         fails++;
         $display("FAIL fifo_full: got level=%0d host_ready=%b, required 8 0", fifo_level, host_ready);
      end
      mmr_busy = 1'b0;
      while (fifo_level == 4'd8 && n < 10) begin
         step();
         n++;
      end
      tests++;
      if ({fifo_level, host_ready} !== {4'd7, 1'b1}) begin
         fails++;
         $display("FAIL fifo_after_grant: got level=%0d host_ready=%b, required 7 1", fifo_level, host_ready);
      end
      drain(300, "fifo_full");
   endtask

   task automatic test_arbitration();
      do_reset();
`ifdef JT12_WRSEQ_PCM_PRIO_EN
      exp_write(1'b0, 8'h2A, 8'h40);
      exp_write(1'b1, 8'hA4, 8'h22);
`else
      exp_write(1'b1, 8'hA4, 8'h22);
      exp_write(1'b0, 8'h2A, 8'h40);
`endif
      host_valid = 1'b1;
      host_part  = 1'b1;
      host_reg   = 8'hA4;
      host_data  = 8'h22;
      pcm_valid  = 1'b1;
      pcm_data   = 8'h40;
      step();
      host_valid = 1'b0;
      pcm_valid  = 1'b0;
      drain(40, "arbitration");
   endtask

   task automatic test_busy_hold();
      int cnt = 0;
      logic [2:0] pat;
      do_reset();
      exp_write(1'b0, 8'h11, 8'h01);
      host_push(1'b0, 8'h11, 8'h01);
      wait_data_strobe("busy_first");
      mmr_busy = 1'b1;
      exp_write(1'b0, 8'h11, 8'h02);
      host_push(1'b0, 8'h11, 8'h02);
      repeat (40) begin
         step();
         if (mmr_write) cnt++;
      end
      tests++;
      if (cnt != 0) begin
         fails++;
         $display("FAIL busy_40: got %0d strobes while busy, required 0", cnt);
      end
      mmr_busy = 1'b0;
      // Busy is first seen low at the next edge; the strobe follows two cycles later.
      for (int i = 0; i < 3; i++) begin
         step();
         pat[i] = mmr_write;
      end
      tests++;
      if (pat !== 3'b100 || mmr_addr !== 2'd1) begin
         fail_busy_release(pat);
      end
      drain(20, "busy_hold");
   endtask

   task automatic fail_busy_release(input logic [2:0] pat);
      fails++;
      $display("FAIL busy_release: pattern got %b addr=%0d, required 001 (LSB first) addr=1", pat, mmr_addr);
   endtask

   task automatic test_reset_mid();
      do_reset();
      exp_write(1'b0, 8'h28, 8'hF0);
      host_push(1'b0, 8'h28, 8'hF0);
      host_push(1'b0, 8'h29, 8'h33);
      step();                                  // address strobe, FSM now in S_GAP1
      tests++;
      if (mmr_write !== 1'b1) begin
         fails++;
         $display("FAIL mid_addr_strobe: got wr=%b, required 1", mmr_write);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({mmr_write, fifo_level} !== {1'b0, 4'd0}) begin
         fails++;
         $display("FAIL async_reset: got wr=%b level=%0d, required 0 0", mmr_write, fifo_level);
      end
      exp_q.delete();
      msv = 1'b0;
      prev_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_write(1'b0, 8'h28, 8'h77);
      host_push(1'b0, 8'h28, 8'h77);
      step();
      step();
      tests++;
      if ({mmr_write, mmr_addr, mmr_din} !== {1'b1, 2'd0, 8'h28}) begin
         fails++;
         $display("FAIL post_reset_addr: got wr=%b addr=%0d din=%02h, required 1 0 28", mmr_write, mmr_addr, mmr_din);
      end
      drain(20, "reset_mid");
   endtask

   initial begin
      test_reset();
      test_host_write();
      test_pcm_pair();
      test_fifo_full();
      test_arbitration();
      test_busy_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
